// File: rtl/imm_gen.sv
// RV32I decode-stage immediate generator: picks the I/S/B/U/J immediate from an
// instruction word and registers it, with its format code, across the ID/EX boundary.
module imm_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] instr,
  output logic [31:0] immOut,
  output logic [2:0]  immType
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  fmt_t        fmt;
  logic [31:0] imm_next;

  // Only the opcode selects the format; funct3/funct7 never matter here.
  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      default:                  fmt = FMT_NONE;
    endcase
  end

  // Shift-immediates take the plain I path, so funct7 lands in imm[11:5].
  always_comb begin
    imm_next = 32'd0;
    case (fmt)
      FMT_I:   imm_next = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm_next = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm_next = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
      FMT_U:   imm_next = {instr[31:12], 12'd0};
      FMT_J:   imm_next = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
      default: imm_next = 32'd0;
    endcase
  end

  // en=1 advances the stage; en=0 stalls and holds both outputs. Reset wins over en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      immOut  <= 32'd0;
      immType <= FMT_NONE;
    end else if (en) begin
      immOut  <= imm_next;
      immType <= fmt;
    end
  end

endmodule

// File: tb/tb_imm_gen.sv
// Bench for imm_gen: directed vectors with literal expectations plus a
// behavioural reference model compared against the DUT on every cycle.
module tb_imm_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] instr;
  logic [31:0] immOut;
  logic [2:0]  immType;

  int checks;
  int errors;

  logic [31:0] mdl_imm;
  logic [2:0]  mdl_type;
  logic        mdl_valid;

  imm_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .instr   (instr),
    .immOut  (immOut),
    .immType (immType)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Immediates rebuilt by shifting/masking fields of the word as a signed int.
  function automatic void ref_decode(input logic [31:0] i,
                                     output logic [31:0] imm,
                                     output logic [2:0] t);
    int s;
    int u;
    s = int'(i);
    u = 0;
    t = 3'd0;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin
        t = 3'd1;
        u = s >>> 20;
      end
      7'b0100011: begin
        t = 3'd2;
        u = ((s >>> 25) * 32) + int'((i >> 7) & 32'd31);
      end
      7'b1100011: begin
        t = 3'd3;
        u = ((s >>> 31) * 4096) + int'(((i >> 7) & 32'd1) * 2048)
          + int'(((i >> 25) & 32'd63) * 32) + int'(((i >> 8) & 32'd15) * 2);
      end
      7'b0110111, 7'b0010111: begin
        t = 3'd4;
        u = int'(i & 32'hFFFF_F000);
      end
      7'b1101111: begin
        t = 3'd5;
        u = ((s >>> 31) * 1048576) + int'(((i >> 12) & 32'd255) * 4096)
          + int'(((i >> 20) & 32'd1) * 2048) + int'(((i >> 21) & 32'd1023) * 2);
      end
      default: begin
        t = 3'd0;
        u = 0;
      end
    endcase
    imm = 32'(u);
  endfunction

  always @(posedge clk) begin
    logic [31:0] d_imm;
    logic [2:0]  d_t;
    ref_decode(instr, d_imm, d_t);
    if (rst_n === 1'b0) begin
      mdl_imm   <= 32'd0;
      mdl_type  <= 3'd0;
      mdl_valid <= 1'b1;
    end else if (en === 1'b1) begin
      mdl_imm  <= d_imm;
      mdl_type <= d_t;
    end
  end

  initial mdl_valid = 1'b0;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (mdl_valid) begin
      checks++;
      if (immOut !== mdl_imm || immType !== mdl_type) begin
        errors++;
        $display("FAIL model_cmp t=%0t instr=%08h got imm=%08h type=%0d want imm=%08h type=%0d",
                 $time, instr, immOut, immType, mdl_imm, mdl_type);
      end
    end
  end

  // ---------------- driver / literal checks ----------------
  task automatic step(input logic e, input logic [31:0] ins);
    en    = e;
    instr = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [31:0] imm,
                            input logic [2:0] t);
    checks++;
    if (immOut !== imm || immType !== t) begin
      errors++;
      $display("FAIL %s got imm=%08h type=%0d want imm=%08h type=%0d",
               name, immOut, immType, imm, t);
    end
  endtask

  task automatic vec(input string name, input logic [31:0] ins,
                     input logic [31:0] imm, input logic [2:0] t);
    step(1'b1, ins);
    expect_out(name, imm, t);
  endtask

  logic [6:0] ops [12];

  initial begin
    checks = 0;
    errors = 0;
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1110011,
            7'b0001111, 7'b1111111};

    rst_n = 1'b0;
    en    = 1'b1;
    instr = 32'hFFF0_0093;
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_out("reset", 32'h0000_0000, 3'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out("post_reset_addi_m1", 32'hFFFF_FFFF, 3'd1);

    vec("addi_2",      32'h0020_0093, 32'h0000_0002, 3'd1);
    vec("jalr_8",      32'h0081_0067, 32'h0000_0008, 3'd1);
    vec("addi_m1",     32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1);
    vec("srai_funct7", 32'h4030_D093, 32'h0000_0403, 3'd1);
    vec("sw_16",       32'h0031_2823, 32'h0000_0010, 3'd2);
    vec("beq_p12",     32'h0020_8663, 32'h0000_000C, 3'd3);
    vec("beq_m4",      32'hFE00_0EE3, 32'hFFFF_FFFC, 3'd3);
    vec("lui",         32'h1234_50B7, 32'h1234_5000, 3'd4);
    vec("auipc",       32'h00AB_D097, 32'h00AB_D000, 3'd4);
    vec("jal_2048",    32'h0010_00EF, 32'h0000_0800, 3'd5);
    vec("jal_m2",      32'hFFFF_F0EF, 32'hFFFF_FFFE, 3'd5);
    vec("illegal_op",  32'hFFFF_FFFF, 32'h0000_0000, 3'd0);
    vec("add_rtype",   32'h0020_81B3, 32'h0000_0000, 3'd0);

    vec("stall_load", 32'h0020_0093, 32'h0000_0002, 3'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h1234_50B7);
      expect_out("stall_hold", 32'h0000_0002, 3'd1);
    end
    vec("stall_release", 32'h1234_50B7, 32'h1234_5000, 3'd4);

    rst_n = 1'b0;
    step(1'b0, 32'h1234_50B7);
    expect_out("reset_over_stall", 32'h0000_0000, 3'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 60; k++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 11)];
      step(($urandom_range(0, 3) != 0), w);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
